gps_iq_collector: RTL and testbench

- Sits directly downstream of one GPS channel demodulator.
- On each code epoch (ms0) it drives the demodulator's shift strobe and deserialises the serial IQ accumulator stream (sout), MSB first.
- Each accumulator is packed into a 32-bit sign-extended word. A header word plus the accumulator words form one record, which is buffered in a word FIFO for the embedded CPU to pop.
- Replaces bit-banged shifting by the CPU and makes epoch loss visible.

---
 rtl/gps_iq_collector.sv | 233 +++++++++++++++++++++++
 tb/tb_gps_iq_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_iq_collector.sv
// gps_iq_collector
// Collects one GPS channel's serial IQ accumulators into a word FIFO, one
// record per code epoch.
//
// On each enabled epoch pulse the block strobes the demodulator's shift line
// and deserialises N_ACC accumulators (INTEG_BITS each, MSB first). Each
// accumulator becomes one sign-extended 32-bit word. A header word goes in
// front of the accumulator words, and the record is queued for the CPU.
// Header layout: {epoch_cnt[15:0], drop_cnt[7:0], 3'b0, e1b_flag, N_ACC[3:0]}.
// A record that cannot fit is still shifted out, so the demodulator stream
// stays aligned, but nothing from it is written.
//
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous reset, active low
//   en       collection enable; gates only the start of a record
//   ms0      epoch pulse from the demodulator
//   sout     serial IQ data from the demodulator
//   shift    shift strobe to the demodulator
//   rd       CPU pop strobe
//   dout     FIFO head word (show-ahead), 0 while empty
//   empty    FIFO empty
//   level    number of words held in the FIFO
//   overrun  sticky: at least one epoch record was dropped
//   clr_ovr  clears overrun and the drop counter
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | wait for ms0&en; decide admission, write header if kept
// ARM    | one quiet cycle while the demodulator loads its shift register
// SHIFT  | shift strobe high, one stream bit per cycle
// DONE   | flush the last pending word, back to IDLE

module gps_iq_collector #(
    parameter int INTEG_BITS = 18,
    parameter int N_ACC      = 6,
    parameter int FIFO_DEPTH = 64,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          ms0,
    input  logic          sout,
    output logic          shift,
    input  logic          rd,
    output logic [31:0]   dout,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          overrun,
    input  logic          clr_ovr
);

    localparam int BW = $clog2(INTEG_BITS);
    localparam int WW = (N_ACC > 1) ? $clog2(N_ACC) : 1;

    localparam logic [BW-1:0] BIT_MAX   = BW'(INTEG_BITS - 1);
    localparam logic [WW-1:0] WORD_MAX  = WW'(N_ACC - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] NEED_L    = LW'(N_ACC + 1);
    localparam logic [3:0]    NACC4     = 4'(N_ACC);
    localparam logic          E1B_FLAG  = (N_ACC == 12);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [BW-1:0]         r_bit_cnt;
    logic [WW-1:0]         r_word_cnt;
    logic [INTEG_BITS-2:0] r_sh;
    logic                  r_keep;
    logic                  r_wr_pend;
    logic [31:0]           r_wr_word;
    logic [15:0]           r_epoch_cnt;
    logic [7:0]            r_drop_cnt;
    logic                  r_overrun;

    logic [31:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;

    logic                  w_epoch;
    logic                  w_admit;
    logic                  w_start;
    logic                  w_drop;
    logic                  w_hdr_wr;
    logic                  w_last_bit;
    logic                  w_last_word;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_empty;
    logic [31:0]           w_wdata;
    logic [31:0]           w_header;
    logic [15:0]           w_epoch_nxt;
    logic [INTEG_BITS-1:0] w_sh_next;
    logic [31:0]           w_ext;

    // ---------------- control decode ----------------
    assign w_epoch     = ms0 & en;
    assign w_admit     = (DEPTH_L - r_level) >= NEED_L;
    assign w_start     = w_epoch && (r_state == S_IDLE);
    // Any epoch that does not start a kept record is a drop, including
    // epochs arriving while a record is still being shifted.
    assign w_drop      = w_epoch && ((r_state != S_IDLE) || !w_admit);
    assign w_hdr_wr    = w_start && w_admit;
    assign w_last_bit  = shift && (r_bit_cnt == '0);
    assign w_last_word = w_last_bit && (r_word_cnt == '0);

    assign w_epoch_nxt = r_epoch_cnt + 16'd1;
    assign w_header    = {w_epoch_nxt, r_drop_cnt, 3'b000, E1B_FLAG, NACC4};

    // The bit arriving this cycle completes the word on the terminal count.
    assign w_sh_next   = {r_sh, sout};
    assign w_ext       = 32'($signed(w_sh_next));

    // Header writes only happen in IDLE and pending words never survive past
    // DONE, so the two write sources cannot collide.
    assign w_wr        = w_hdr_wr | r_wr_pend;
    assign w_wdata     = w_hdr_wr ? w_header : r_wr_word;

    assign w_empty     = (r_level == '0);
    assign w_rd        = rd & ~w_empty;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_epoch) w_state_nxt = S_ARM;
            S_ARM:   w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_word) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        shift = 1'b0;
        if (r_state == S_SHIFT) shift = 1'b1;
    end

    // ---------------- deserialiser and record bookkeeping ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_sh        <= '0;
            r_keep      <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wr_word   <= '0;
            r_epoch_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_state == S_ARM) begin
                r_bit_cnt  <= BIT_MAX;
                r_word_cnt <= WORD_MAX;
            end else if (shift) begin
                r_sh <= w_sh_next[INTEG_BITS-2:0];
                if (r_bit_cnt == '0) begin
                    r_bit_cnt  <= BIT_MAX;
                    r_word_cnt <= r_word_cnt - 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                end
            end

            r_wr_pend <= w_last_bit && r_keep;
            if (w_last_bit) r_wr_word <= w_ext;

            if (w_start) r_keep <= w_admit;

            if (w_epoch) r_epoch_cnt <= w_epoch_nxt;

            // A drop in the same cycle as a clear wins and counts as one drop.
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (clr_ovr)
                    r_drop_cnt <= 8'd1;
                else if (r_drop_cnt != 8'hFF)
                    r_drop_cnt <= r_drop_cnt + 8'd1;
            end else if (clr_ovr) begin
                r_overrun  <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    // ---------------- word FIFO ----------------
    // Storage has no reset so it can map onto RAM; only pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout    = w_empty ? 32'd0 : r_mem[r_rd_ptr];
    assign empty   = w_empty;
    assign level   = r_level;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_gps_iq_collector.sv
module tb_gps_iq_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        en_a, ms0_a, sout_a, rd_a, clr_a;
    logic        shift_a, empty_a, overrun_a;
    logic [31:0] dout_a;
    logic [4:0]  level_a;

    logic        en_e, ms0_e, sout_e, rd_e, clr_e;
    logic        shift_e, empty_e, overrun_e;
    logic [31:0] dout_e;
    logic [6:0]  level_e;

    int checks = 0;
    int errors = 0;

    logic [17:0] stream_a [6];
    logic [31:0] exp_a    [7];
    logic [17:0] stream_e [12];
    logic [31:0] exp_e    [13];

    gps_iq_collector #(.INTEG_BITS(18), .N_ACC(6), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .ms0(ms0_a), .sout(sout_a),
        .shift(shift_a), .rd(rd_a), .dout(dout_a), .empty(empty_a),
        .level(level_a), .overrun(overrun_a), .clr_ovr(clr_a)
    );

    gps_iq_collector #(.INTEG_BITS(18), .N_ACC(12), .FIFO_DEPTH(64)) dut_e (
        .clk(clk), .rst(rst), .en(en_e), .ms0(ms0_e), .sout(sout_e),
        .shift(shift_e), .rd(rd_e), .dout(dout_e), .empty(empty_e),
        .level(level_e), .overrun(overrun_e), .clr_ovr(clr_e)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        en_a = 0; ms0_a = 0; sout_a = 0; rd_a = 0; clr_a = 0;
        en_e = 0; ms0_e = 0; sout_e = 0; rd_e = 0; clr_e = 0;
        step;
        step;
        rst = 1'b1;
    endtask

    // Runs one epoch on dut_a. rd_at / ms0_at select the shift cycle in which
    // rd (resp. ms0+clr_ovr) is pulsed; -1 disables. Returns observations only.
    task automatic epoch_a(input int rd_at, input int ms0_at, output int nshift,
                           output logic sh_arm, output logic sh_first,
                           output logic [4:0] lvl_before, output logic [4:0] lvl_after);
        ms0_a = 1'b1;
        step;
        ms0_a = 1'b0;
        sh_arm = shift_a;
        step;
        sh_first = shift_a;
        nshift = 0;
        lvl_before = '0;
        lvl_after = '0;
        while (shift_a === 1'b1 && nshift < 400) begin
            sout_a = (nshift < 108) ? stream_a[nshift / 18][17 - (nshift % 18)] : 1'b0;
            rd_a   = (nshift == rd_at);
            ms0_a  = (nshift == ms0_at);
            clr_a  = (nshift == ms0_at);
            if (nshift == rd_at) lvl_before = level_a;
            if (rd_at >= 0 && nshift == rd_at + 1) lvl_after = level_a;
            nshift++;
            step;
        end
        rd_a = 0; ms0_a = 0; clr_a = 0; sout_a = 0;
        step;
    endtask

    task automatic epoch_e(output int nshift);
        ms0_e = 1'b1;
        step;
        ms0_e = 1'b0;
        step;
        nshift = 0;
        while (shift_e === 1'b1 && nshift < 400) begin
            sout_e = (nshift < 216) ? stream_e[nshift / 18][17 - (nshift % 18)] : 1'b0;
            nshift++;
            step;
        end
        sout_e = 0;
        step;
    endtask

    task automatic test_reset;
        apply_reset;
        checks++; if (shift_a !== 1'b0)   begin errors++; $display("FAIL reset_shift: got %b want 0", shift_a); end
        checks++; if (empty_a !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", empty_a); end
        checks++; if (level_a !== 5'd0)   begin errors++; $display("FAIL reset_level: got %0d want 0", level_a); end
        checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_a); end
        checks++; if (dout_a !== 32'd0)   begin errors++; $display("FAIL reset_dout: got %h want 0", dout_a); end
        checks++; if (level_e !== 7'd0)   begin errors++; $display("FAIL reset_level_e: got %0d want 0", level_e); end
    endtask

    task automatic test_single_epoch;
        int n; logic sa, sf; logic [4:0] lb, la;
        stream_a = '{18'h00001, 18'h3FFFF, 18'h1FFFF, 18'h20000, 18'h00005, 18'h00000};
        exp_a    = '{32'h00010006, 32'h00000001, 32'hFFFFFFFF, 32'h0001FFFF,
                     32'hFFFE0000, 32'h00000005, 32'h00000000};
        en_a = 1'b1;
        epoch_a(-1, -1, n, sa, sf, lb, la);
        checks++; if (sa !== 1'b0) begin errors++; $display("FAIL single_arm_shift: got %b want 0", sa); end
        checks++; if (sf !== 1'b1) begin errors++; $display("FAIL single_shift_start: got %b want 1", sf); end
        checks++; if (n != 108)    begin errors++; $display("FAIL single_shift_len: got %0d want 108", n); end
        checks++; if (level_a !== 5'd7) begin errors++; $display("FAIL single_level: got %0d want 7", level_a); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dout_a !== exp_a[i]) begin errors++; $display("FAIL single_word%0d: got %h want %h", i, dout_a, exp_a[i]); end
            rd_a = 1'b1; step; rd_a = 1'b0;
        end
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL single_drained: got %b want 1", empty_a); end
    endtask

    task automatic test_reads;
        int n; logic sa, sf; logic [4:0] lb, la;
        rd_a = 1'b1; step; rd_a = 1'b0;
        checks++; if (level_a !== 5'd0) begin errors++; $display("FAIL rd_empty_level: got %0d want 0", level_a); end
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL rd_empty_flag: got %b want 1", empty_a); end
        // Pop the header in the cycle word 0 is written.
        epoch_a(18, -1, n, sa, sf, lb, la);
        checks++; if (lb !== 5'd1) begin errors++; $display("FAIL rd_wr_level_before: got %0d want 1", lb); end
        checks++; if (la !== 5'd1) begin errors++; $display("FAIL rd_wr_level_after: got %0d want 1", la); end
        checks++; if (level_a !== 5'd6) begin errors++; $display("FAIL rd_wr_final_level: got %0d want 6", level_a); end
        for (int i = 1; i < 7; i++) begin
            checks++;
            if (dout_a !== exp_a[i]) begin errors++; $display("FAIL rd_word%0d: got %h want %h", i, dout_a, exp_a[i]); end
            rd_a = 1'b1; step; rd_a = 1'b0;
        end
    endtask

    task automatic test_full_fifo;
        int n; logic sa, sf; logic [4:0] lb, la;
        apply_reset;
        en_a = 1'b1;
        epoch_a(-1, -1, n, sa, sf, lb, la);
        epoch_a(-1, -1, n, sa, sf, lb, la);
        checks++; if (level_a !== 5'd14) begin errors++; $display("FAIL full_level2: got %0d want 14", level_a); end
        epoch_a(-1, -1, n, sa, sf, lb, la);
        checks++; if (n != 108)            begin errors++; $display("FAIL full_drop_shift_len: got %0d want 108", n); end
        checks++; if (overrun_a !== 1'b1)  begin errors++; $display("FAIL full_overrun: got %b want 1", overrun_a); end
        checks++; if (level_a !== 5'd14)   begin errors++; $display("FAIL full_level3: got %0d want 14", level_a); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dout_a !== exp_a[i]) begin errors++; $display("FAIL full_e1_word%0d: got %h want %h", i, dout_a, exp_a[i]); end
            rd_a = 1'b1; step; rd_a = 1'b0;
        end
        epoch_a(-1, -1, n, sa, sf, lb, la);
        checks++; if (level_a !== 5'd14) begin errors++; $display("FAIL full_level4: got %0d want 14", level_a); end
        exp_a[0] = 32'h00020006;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dout_a !== exp_a[i]) begin errors++; $display("FAIL full_e2_word%0d: got %h want %h", i, dout_a, exp_a[i]); end
            rd_a = 1'b1; step; rd_a = 1'b0;
        end
        exp_a[0] = 32'h00040106;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dout_a !== exp_a[i]) begin errors++; $display("FAIL full_e4_word%0d: got %h want %h", i, dout_a, exp_a[i]); end
            rd_a = 1'b1; step; rd_a = 1'b0;
        end
    endtask

    task automatic test_ms0_during_shift;
        int n; logic sa, sf; logic [4:0] lb, la;
        // Epoch 5 is kept; epoch 6 lands mid-shift together with clr_ovr.
        epoch_a(-1, 50, n, sa, sf, lb, la);
        checks++; if (n != 108)           begin errors++; $display("FAIL midms0_shift_len: got %0d want 108", n); end
        checks++; if (overrun_a !== 1'b1) begin errors++; $display("FAIL midms0_overrun: got %b want 1", overrun_a); end
        checks++; if (level_a !== 5'd7)   begin errors++; $display("FAIL midms0_level: got %0d want 7", level_a); end
        exp_a[0] = 32'h00050106;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dout_a !== exp_a[i]) begin errors++; $display("FAIL midms0_word%0d: got %h want %h", i, dout_a, exp_a[i]); end
            rd_a = 1'b1; step; rd_a = 1'b0;
        end
        epoch_a(-1, -1, n, sa, sf, lb, la);
        exp_a[0] = 32'h00070106;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dout_a !== exp_a[i]) begin errors++; $display("FAIL after_midms0_word%0d: got %h want %h", i, dout_a, exp_a[i]); end
            rd_a = 1'b1; step; rd_a = 1'b0;
        end
    endtask

    task automatic test_enable_gate;
        en_a = 1'b0;
        ms0_a = 1'b1; step; ms0_a = 1'b0;
        step; step;
        checks++; if (shift_a !== 1'b0) begin errors++; $display("FAIL en_gate_shift: got %b want 0", shift_a); end
        checks++; if (level_a !== 5'd0) begin errors++; $display("FAIL en_gate_level: got %0d want 0", level_a); end
        en_a = 1'b1;
    endtask

    task automatic test_reset_mid;
        int n; logic sa, sf; logic [4:0] lb, la;
        ms0_a = 1'b1; step; ms0_a = 1'b0;
        step;
        for (int k = 0; k < 30; k++) begin
            sout_a = stream_a[k / 18][17 - (k % 18)];
            step;
        end
        checks++; if (level_a === 5'd0) begin errors++; $display("FAIL rstmid_pre_level: got %0d want nonzero", level_a); end
        rst = 1'b0;
        step;
        rst = 1'b1;
        sout_a = 1'b0;
        checks++; if (shift_a !== 1'b0)   begin errors++; $display("FAIL rstmid_shift: got %b want 0", shift_a); end
        checks++; if (empty_a !== 1'b1)   begin errors++; $display("FAIL rstmid_empty: got %b want 1", empty_a); end
        checks++; if (level_a !== 5'd0)   begin errors++; $display("FAIL rstmid_level: got %0d want 0", level_a); end
        checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b want 0", overrun_a); end
        en_a = 1'b1;
        epoch_a(-1, -1, n, sa, sf, lb, la);
        checks++; if (level_a !== 5'd7) begin errors++; $display("FAIL rstmid_next_level: got %0d want 7", level_a); end
        exp_a[0] = 32'h00010006;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dout_a !== exp_a[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h want %h", i, dout_a, exp_a[i]); end
            rd_a = 1'b1; step; rd_a = 1'b0;
        end
    endtask

    task automatic test_e1b;
        int n;
        stream_e = '{18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h00005, 18'h00006,
                     18'h3FFFE, 18'h20001, 18'h1FFFE, 18'h00007, 18'h00008, 18'h00009};
        exp_e    = '{32'h0001001C, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
                     32'h00000005, 32'h00000006, 32'hFFFFFFFE, 32'hFFFE0001, 32'h0001FFFE,
                     32'h00000007, 32'h00000008, 32'h00000009};
        en_e = 1'b1;
        epoch_e(n);
        checks++; if (n != 216)          begin errors++; $display("FAIL e1b_shift_len: got %0d want 216", n); end
        checks++; if (level_e !== 7'd13) begin errors++; $display("FAIL e1b_level: got %0d want 13", level_e); end
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (dout_e !== exp_e[i]) begin errors++; $display("FAIL e1b_word%0d: got %h want %h", i, dout_e, exp_e[i]); end
            rd_e = 1'b1; step; rd_e = 1'b0;
        end
        checks++; if (empty_e !== 1'b1) begin errors++; $display("FAIL e1b_drained: got %b want 1", empty_e); end
    endtask

    initial begin
        rst = 1'b0;
        test_reset;
        test_single_epoch;
        test_reads;
        test_full_fifo;
        test_ms0_during_shift;
        test_enable_gate;
        test_reset_mid;
        test_e1b;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
